// File: rtl/subword_seq.sv
// Sequential AES SubWord / key-expansion g() engine: NBYTES bytes pushed through
// NSBOX shared S-boxes, one byte group per cycle, with valid/ready on both sides.

module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] sub
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] pw;

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; zero maps to zero.
  always_comb begin
    pw  = data;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
  end

  assign sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module subword_seq #(
  parameter int NBYTES = 4,
  parameter int NSBOX  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_word,
  input  logic                  rot_en,
  input  logic [7:0]            rcon,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_word,
  output logic                  busy
);

  localparam int W    = 8 * NBYTES;
  localparam int NGRP = NBYTES / NSBOX;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int BW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (NBYTES % NSBOX != 0) begin : g_bad_param
    $error("subword_seq: NSBOX must divide NBYTES");
  end

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [NBYTES-1:0][7:0]   data_r;
  logic [NBYTES-1:0][7:0]   result_r;
  logic [NBYTES-1:0][7:0]   next_result;
  logic [7:0]               rcon_r;
  logic [NSBOX-1:0][7:0]    sb_in;
  logic [NSBOX-1:0][7:0]    sb_out;
  logic [W-1:0]             rotated;

  // Byte k (0 = most significant) lives in packed slot NBYTES-1-k.
  function automatic logic [BW-1:0] slot(input logic [CW-1:0] c, input int j);
    return BW'(NBYTES - 1 - (int'(c) * NSBOX + j));
  endfunction

  assign rotated = (in_word << 8) | (in_word >> (W - 8));

  always_comb begin
    sb_in = '0;
    for (int j = 0; j < NSBOX; j++) sb_in[j] = data_r[slot(cnt, j)];
  end

  always_comb begin
    next_result = result_r;
    for (int j = 0; j < NSBOX; j++) next_result[slot(cnt, j)] = sb_out[j];
  end

  for (genvar j = 0; j < NSBOX; j++) begin : g_sbox
    aes_sbox u_sbox (.data(sb_in[j]), .sub(sb_out[j]));
  end

  // The final SUB edge loads out_word with the complete result so it is
  // registered and stable for the whole DONE phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      data_r    <= '0;
      result_r  <= '0;
      rcon_r    <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r   <= rot_en ? rotated : in_word;
            rcon_r   <= rcon;
            cnt      <= '0;
            state    <= SUB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SUB: begin
          result_r <= next_result;
          if (cnt == CW'(NGRP - 1)) begin
            cnt                 <= '0;
            state               <= DONE;
            out_valid           <= 1'b1;
            out_word            <= next_result;
            out_word[W-1 -: 8]  <= next_result[NBYTES-1] ^ rcon_r;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subword_seq.sv
// Testbench for subword_seq: directed FIPS-197 vectors, backpressure, mid-operation
// reset and randomized words against a table-driven AES reference model.

module tb_subword_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic        a_in_valid = 0, a_in_ready, a_rot_en = 0, a_out_valid, a_out_ready = 1, a_busy;
  logic [31:0] a_in_word = '0, a_out_word;
  logic [7:0]  a_rcon = '0;

  logic        s_in_valid = 0, s_rot_en = 0, s_out_ready = 1;
  logic [31:0] s_in_word = '0;
  logic [7:0]  s_rcon = '0;
  logic        b_in_ready, b_out_valid, b_busy, c_in_ready, c_out_valid, c_busy;
  logic [31:0] b_out_word, c_out_word;

  logic        d_in_valid = 0, d_in_ready, d_rot_en = 0, d_out_valid, d_out_ready = 1, d_busy;
  logic [63:0] d_in_word = '0, d_out_word;
  logic [7:0]  d_rcon = '0;

  subword_seq #(.NBYTES(4), .NSBOX(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_word(a_in_word), .rot_en(a_rot_en), .rcon(a_rcon), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_word(a_out_word), .busy(a_busy));

  subword_seq #(.NBYTES(4), .NSBOX(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(b_in_ready),
    .in_word(s_in_word), .rot_en(s_rot_en), .rcon(s_rcon), .out_valid(b_out_valid),
    .out_ready(s_out_ready), .out_word(b_out_word), .busy(b_busy));

  subword_seq #(.NBYTES(4), .NSBOX(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(c_in_ready),
    .in_word(s_in_word), .rot_en(s_rot_en), .rcon(s_rcon), .out_valid(c_out_valid),
    .out_ready(s_out_ready), .out_word(c_out_word), .busy(c_busy));

  subword_seq #(.NBYTES(8), .NSBOX(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_word(d_in_word), .rot_en(d_rot_en), .rcon(d_rcon), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_word(d_out_word), .busy(d_busy));

  logic [7:0] sbox_tab [256];

  // Reference multiply: carry-less 16-bit product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Reference S-box: brute-force inverse search followed by the affine bit matrix.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    if (x != 0)
      for (int y = 1; y < 256; y++) if (mul_ref(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [63:0] model_g(input logic [63:0] w, input int n,
                                          input logic rot, input logic [7:0] rc);
    logic [7:0] b [8];
    logic [7:0] t [8];
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) b[k] = w[8*(n-1-k) +: 8];
    for (int k = 0; k < n; k++) t[k] = sbox_tab[rot ? b[(k+1)%n] : b[k]];
    t[0] = t[0] ^ rc;
    for (int k = 0; k < n; k++) r[8*(n-1-k) +: 8] = t[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic apply_stimulus_a(input logic [31:0] w, input logic rot, input logic [7:0] rc,
                                  input logic [31:0] exp, input string tag);
    int lat;
    check_output({tag, "/ready_idle"}, 64'(a_in_ready), 64'd1);
    a_in_word = w; a_rot_en = rot; a_rcon = rc; a_in_valid = 1; a_out_ready = 1;
    tick();
    a_in_valid = 0; a_in_word = $urandom; a_rot_en = 1'($urandom); a_rcon = 8'($urandom);
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 20) begin
      check_output({tag, "/ready_sub"}, 64'(a_in_ready), 64'd0);
      check_output({tag, "/busy_sub"}, 64'(a_busy), 64'd1);
      tick();
      lat++;
    end
    check_output({tag, "/latency"}, 64'(lat), 64'd4);
    check_output({tag, "/word"}, 64'(a_out_word), 64'(exp));
    check_output({tag, "/ready_done"}, 64'(a_in_ready), 64'd0);
    check_output({tag, "/busy_done"}, 64'(a_busy), 64'd1);
    tick();
    check_output({tag, "/valid_after"}, 64'(a_out_valid), 64'd0);
    check_output({tag, "/ready_after"}, 64'(a_in_ready), 64'd1);
    check_output({tag, "/busy_after"}, 64'(a_busy), 64'd0);
  endtask

  task automatic apply_stimulus_bc(input logic [31:0] w, input logic rot, input logic [7:0] rc);
    logic [63:0] exp;
    int lat_b = -1, lat_c = -1;
    logic [31:0] wb = '0, wc = '0;
    exp = model_g(64'(w), 4, rot, rc);
    check_output("bc/ready_b", 64'(b_in_ready), 64'd1);
    check_output("bc/ready_c", 64'(c_in_ready), 64'd1);
    s_in_word = w; s_rot_en = rot; s_rcon = rc; s_in_valid = 1;
    tick();
    s_in_valid = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (b_out_valid === 1'b1 && lat_b < 0) begin lat_b = n; wb = b_out_word; end
      if (c_out_valid === 1'b1 && lat_c < 0) begin lat_c = n; wc = c_out_word; end
    end
    check_output("nsbox2/latency", 64'(lat_b), 64'd2);
    check_output("nsbox4/latency", 64'(lat_c), 64'd1);
    check_output("nsbox2/word", 64'(wb), exp);
    check_output("nsbox4/word", 64'(wc), exp);
  endtask

  task automatic apply_stimulus_d(input logic [63:0] w, input logic rot, input logic [7:0] rc,
                                  input logic [63:0] exp);
    int lat = -1;
    logic [63:0] wd = '0;
    check_output("nb8/ready", 64'(d_in_ready), 64'd1);
    d_in_word = w; d_rot_en = rot; d_rcon = rc; d_in_valid = 1;
    tick();
    d_in_valid = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (d_out_valid === 1'b1 && lat < 0) begin lat = n; wd = d_out_word; end
    end
    check_output("nb8/latency", 64'(lat), 64'd4);
    check_output("nb8/word", wd, exp);
  endtask

  initial begin
    logic [31:0] w, w2;
    logic [63:0] m, m2, wd;
    logic rot;
    logic [7:0] rc;
    int lat;

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_ref(8'(i));

    tick(); tick();
    check_output("reset/in_ready", 64'(a_in_ready), 64'd1);
    check_output("reset/out_valid", 64'(a_out_valid), 64'd0);
    check_output("reset/busy", 64'(a_busy), 64'd0);
    check_output("reset/out_word", 64'(a_out_word), 64'd0);
    rst_n = 1;
    tick();

    apply_stimulus_a(32'h00000000, 1'b0, 8'h00, 32'h63636363, "t1_zero");
    apply_stimulus_a(32'h00010203, 1'b0, 8'h00, 32'h637c777b, "t2_seq");
    apply_stimulus_a(32'h09cf4f3c, 1'b1, 8'h01, 32'h8b84eb01, "t3_fips_g");
    for (int i = 0; i < 12; i++) begin
      w = $urandom; rot = 1'($urandom); rc = 8'($urandom);
      m = model_g(64'(w), 4, rot, rc);
      apply_stimulus_a(w, rot, rc, m[31:0], "rand");
    end

    // Backpressure: second word waits on in_valid while the first is held in DONE.
    w = $urandom; w2 = $urandom;
    m = model_g(64'(w), 4, 1'b1, 8'h36);
    m2 = model_g(64'(w2), 4, 1'b0, 8'h80);
    a_out_ready = 0; a_in_word = w; a_rot_en = 1; a_rcon = 8'h36; a_in_valid = 1;
    tick();
    a_in_word = w2; a_rot_en = 0; a_rcon = 8'h80;
    wait_a(lat);
    check_output("bp/latency1", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_output("bp/hold_valid", 64'(a_out_valid), 64'd1);
      check_output("bp/hold_word", 64'(a_out_word), m);
      check_output("bp/hold_ready", 64'(a_in_ready), 64'd0);
    end
    a_out_ready = 1;
    tick();
    check_output("bp/valid_after_xfer", 64'(a_out_valid), 64'd0);
    check_output("bp/ready_after_xfer", 64'(a_in_ready), 64'd1);
    tick();
    a_in_valid = 0;
    check_output("bp/second_accepted", 64'(a_in_ready), 64'd0);
    wait_a(lat);
    check_output("bp/latency2", 64'(lat), 64'd4);
    check_output("bp/word2", 64'(a_out_word), m2);
    tick();

    // Reset asserted in the second SUB cycle aborts the word.
    a_in_word = $urandom; a_in_valid = 1; a_out_ready = 1;
    tick();
    a_in_valid = 0;
    tick();
    #2 rst_n = 0;
    #1;
    check_output("rst_mid/in_ready", 64'(a_in_ready), 64'd1);
    check_output("rst_mid/out_valid", 64'(a_out_valid), 64'd0);
    check_output("rst_mid/busy", 64'(a_busy), 64'd0);
    check_output("rst_mid/out_word", 64'(a_out_word), 64'd0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("rst_mid/no_output", 64'(a_out_valid), 64'd0);
    end
    w = $urandom;
    m = model_g(64'(w), 4, 1'b1, 8'h1b);
    apply_stimulus_a(w, 1'b1, 8'h1b, m[31:0], "rst_mid/next");

    apply_stimulus_bc(32'h00000000, 1'b0, 8'h00);
    apply_stimulus_bc(32'h00010203, 1'b0, 8'h00);
    apply_stimulus_bc(32'h09cf4f3c, 1'b1, 8'h01);
    for (int i = 0; i < 6; i++) apply_stimulus_bc($urandom, 1'($urandom), 8'($urandom));

    apply_stimulus_d(64'h0001020300010203, 1'b0, 8'h00, 64'h637c777b637c777b);
    for (int i = 0; i < 6; i++) begin
      wd = {$urandom, $urandom}; rot = 1'($urandom); rc = 8'($urandom);
      apply_stimulus_d(wd, rot, rc, model_g(wd, 8, rot, rc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
